// File: rtl/pipe_stage_elastic_if.sv
// ============================================================================
// Module  : pipe_stage_elastic_if
// Brief   : valid/ready payload channel used on both sides of pipe_stage_elastic
// Revision: 1.0
// ============================================================================
`default_nettype none

interface pipe_stage_elastic_if #(
  parameter int DATA_W = 64
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

`default_nettype wire

// File: rtl/pipe_stage_elastic.sv
// ============================================================================
// Module  : pipe_stage_elastic
// Brief   : DEPTH-entry elastic pipeline register with stall, flush and bubble
//           insertion. Define PIPE_STAGE_PERF_EN to build the stall/flush counters.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pipe_stage_elastic #(
  parameter int                DATA_W    = 64,
  parameter int                DEPTH     = 2,
  parameter logic [DATA_W-1:0] NOP_VALUE = '0,
  parameter int                CNT_W     = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 stall,
  pipe_stage_elastic_if.slave  in_if,
  pipe_stage_elastic_if.master out_if,
  output logic [2:0]           count,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt
);

  localparam int                PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0]  LAST_IDX = PTR_W'(DEPTH - 1);
  localparam logic [2:0]        DEPTH_C  = 3'(DEPTH);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        count_q, count_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic              live_q, live_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic in_ready;
  logic out_valid;
  logic push;
  logic pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_IDX) ? '0 : p + 1'b1;
  endfunction

  // live_q keeps in_ready low until the first clock edge after reset release
  always_comb begin
    live_d    = 1'b1;
    in_ready  = live_q & ~stall & ~flush & ((count_q < DEPTH_C) | out_if.ready);
    out_valid = (state_q != ST_EMPTY) & ~flush;
    push      = in_if.valid & in_ready;
    pop       = out_valid & out_if.ready & ~stall;
  end

  assign in_if.ready  = in_ready;
  assign out_if.valid = out_valid;
  assign out_if.data  = out_valid ? mem_q[rd_ptr_q] : NOP_VALUE;
  assign count        = count_q;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (flush) begin
      state_d  = ST_EMPTY;
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = next_ptr(wr_ptr_q);
      if (pop)  rd_ptr_d = next_ptr(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_d = count_q + 3'd1;
        2'b01:   count_d = count_q - 3'd1;
        default: count_d = count_q;
      endcase
      if (count_d == 3'd0)         state_d = ST_EMPTY;
      else if (count_d == DEPTH_C) state_d = ST_FULL;
      else                         state_d = ST_PARTIAL;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_EMPTY;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      live_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      live_q   <= live_d;
    end
  end

  // Payload storage carries no reset; validity lives in count_q/state_q
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= in_if.data;
  end

`ifdef PIPE_STAGE_PERF_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W+2:0] flush_sum;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    flush_sum   = {3'b000, flush_cnt_q} + (CNT_W + 3)'(count_q);
    if (in_if.valid && !in_ready && (stall_cnt_q != CNT_MAX))
      stall_cnt_d = stall_cnt_q + 1'b1;
    if (flush)
      flush_cnt_d = (flush_sum > {3'b000, CNT_MAX}) ? CNT_MAX : flush_sum[CNT_W-1:0];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

`default_nettype wire
